// File: rtl/bnn_acc_pkg.sv
// Function codes for the binary-NN accumulator CXU.
package bnn_acc_pkg;
  typedef enum logic [2:0] {
    FN_DOT  = 3'd0,
    FN_MAC  = 3'd1,
    FN_GET  = 3'd2,
    FN_SET  = 3'd3,
    FN_SIGN = 3'd4,
    FN_CLR  = 3'd5
  } bnn_func_e;
endpackage

// File: rtl/cxu_pkg.sv
// Shared CXU-L1 port widths and response status codes.
package cxu_pkg;
  localparam int CXU_REQ_ID_W   = 6;
  localparam int CXU_CXU_ID_W   = 4;
  localparam int CXU_STATE_ID_W = 4;
  localparam int CXU_INSN_W     = 32;
  localparam int CXU_STATUS_W   = 3;

  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_SUCCESS = 3'd0;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_ERROR   = 3'd1;
endpackage

// File: rtl/bnn_acc_l1_cxu_if.sv
// CXU-L1 request/response port bundle.
interface bnn_acc_l1_cxu_if #(
  parameter int DATA_W    = 32,
  parameter int FUNC_ID_W = 3
);
  import cxu_pkg::*;

  logic                      req_valid;
  logic [CXU_REQ_ID_W-1:0]   req_id;
  logic [CXU_CXU_ID_W-1:0]   req_cxu;
  logic [CXU_STATE_ID_W-1:0] req_state;
  logic [FUNC_ID_W-1:0]      req_func;
  logic [CXU_INSN_W-1:0]     req_insn;
  logic [DATA_W-1:0]         req_data0;
  logic [DATA_W-1:0]         req_data1;

  logic                      resp_valid;
  logic [CXU_REQ_ID_W-1:0]   resp_id;
  logic [CXU_STATUS_W-1:0]   resp_status;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_id, req_cxu, req_state,
    output req_func, req_insn, req_data0, req_data1,
    input  resp_valid, resp_id, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_id, req_cxu, req_state,
    input  req_func, req_insn, req_data0, req_data1,
    output resp_valid, resp_id, resp_status, resp_data
  );
endinterface

// File: rtl/bnn_popcount.sv
// Combinational popcount as a recursive binary adder tree.
module bnn_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]         bits,
  output logic [$clog2(W+1)-1:0] count
);
  localparam int OW = $clog2(W + 1);

  if (W == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_split
    localparam int LW = W / 2;
    localparam int HW = W - LW;

    logic [$clog2(LW+1)-1:0] lo_cnt;
    logic [$clog2(HW+1)-1:0] hi_cnt;

    bnn_popcount #(.W(LW)) u_lo (
      .bits  (bits[LW-1:0]),
      .count (lo_cnt)
    );

    bnn_popcount #(.W(HW)) u_hi (
      .bits  (bits[W-1:LW]),
      .count (hi_cnt)
    );

    assign count = OW'(lo_cnt) + OW'(hi_cnt);
  end
endmodule

// File: rtl/bnn_acc_l1_cxu.sv
// Binary-NN XNOR-popcount dot / saturating accumulator CXU, 2-cycle latency.
module bnn_acc_l1_cxu
  import cxu_pkg::*;
  import bnn_acc_pkg::*;
#(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 4,
  parameter int CXU_LAT       = 2,
  parameter int CXU_RESET_LAT = 0,
  parameter int CXU_FUNC_ID_W = 3,
  parameter int CXU_DATA_W    = 32
) (
  input logic             clk,
  input logic             rst,
  bnn_acc_l1_cxu_if.slave cxu
);
  localparam int W    = CXU_DATA_W;
  localparam int PC_W = $clog2(W + 1);
  localparam int SI_W =
    (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;

  if (CXU_N_CXUS != 1) begin : g_chk_ncxus
    $error("CXU_N_CXUS must be 1");
  end
  if (CXU_N_STATES < 1 || CXU_N_STATES > 16 ||
      CXU_N_STATES > (1 << CXU_STATE_ID_W)) begin : g_chk_nst
    $error("CXU_N_STATES out of range");
  end
  if (CXU_RESET_LAT != 0) begin : g_chk_rlat
    $error("CXU_RESET_LAT must be 0");
  end
  if (CXU_FUNC_ID_W < 3) begin : g_chk_fid
    $error("CXU_FUNC_ID_W must be at least 3");
  end
  if (CXU_LAT != 2) begin : g_chk_lat
    $error("CXU_LAT must be 2");
  end
  if (W != 32 && W != 64) begin : g_chk_dw
    $error("CXU_DATA_W must be 32 or 64");
  end

  logic [W-1:0]    xnor_v;
  logic [PC_W-1:0] pc;
  logic            req_err;

  assign xnor_v = ~(cxu.req_data0 ^ cxu.req_data1);

  bnn_popcount #(.W(W)) u_pop (
    .bits  (xnor_v),
    .count (pc)
  );

  assign req_err =
    (int'(cxu.req_func) > int'(FN_CLR)) ||
    (int'(cxu.req_state) >= CXU_N_STATES) ||
    (cxu.req_cxu != '0);

  logic                    v1;
  logic                    err1;
  logic [CXU_REQ_ID_W-1:0] id1;
  bnn_func_e               func1;
  logic [SI_W-1:0]         st1;
  logic [W-1:0]            a1;
  logic [PC_W-1:0]         pc1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= cxu.req_valid;
    end
    err1  <= req_err;
    id1   <= cxu.req_id;
    func1 <= bnn_func_e'(cxu.req_func[2:0]);
    st1   <= cxu.req_state[SI_W-1:0];
    a1    <= cxu.req_data0;
    pc1   <= pc;
  end

  logic [W-1:0] acc [CXU_N_STATES];
  logic [W-1:0] acc_cur;
  logic [W+1:0] d_x;
  logic [W-1:0] d_w;
  logic [W:0]   sum;
  logic [W-1:0] mac_v;
  logic         ge;

  assign acc_cur = acc[st1];
  // d = 2*popcount - W; magnitude never exceeds W so W bits suffice
  assign d_x = (W+2)'({pc1, 1'b0}) - (W+2)'(W);
  assign d_w = d_x[W-1:0];
  assign sum = {acc_cur[W-1], acc_cur} + {d_w[W-1], d_w};
  assign ge  = $signed(acc_cur) >= $signed(a1);

  always_comb begin
    mac_v = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      mac_v = sum[W] ? {1'b1, {(W-1){1'b0}}}
                     : {1'b0, {(W-1){1'b1}}};
    end
  end

  logic         ok1;
  logic         wr_en;
  logic [W-1:0] wr_val;
  logic [W-1:0] nxt_data;
  logic         st_err;

  assign ok1 = !err1;

  always_comb begin
    wr_en    = 1'b0;
    wr_val   = '0;
    nxt_data = '0;
    st_err   = 1'b0;
    unique case (1'b1)
      err1: st_err = 1'b1;
      ok1 && func1 == FN_DOT: nxt_data = d_w;
      ok1 && func1 == FN_MAC: begin
        wr_en    = 1'b1;
        wr_val   = mac_v;
        nxt_data = mac_v;
      end
      ok1 && func1 == FN_GET: nxt_data = acc_cur;
      ok1 && func1 == FN_SET: begin
        wr_en    = 1'b1;
        wr_val   = a1;
        nxt_data = acc_cur;
      end
      ok1 && func1 == FN_SIGN: nxt_data = W'(ge);
      ok1 && func1 == FN_CLR: begin
        wr_en    = 1'b1;
        nxt_data = acc_cur;
      end
      default: st_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cxu.resp_valid  <= 1'b0;
      cxu.resp_id     <= '0;
      cxu.resp_status <= CXU_STATUS_SUCCESS;
      cxu.resp_data   <= '0;
      for (int i = 0; i < CXU_N_STATES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      cxu.resp_valid  <= v1;
      cxu.resp_id     <= v1 ? id1 : '0;
      cxu.resp_data   <= v1 ? nxt_data : '0;
      cxu.resp_status <= (v1 && st_err) ? CXU_STATUS_ERROR
                                        : CXU_STATUS_SUCCESS;
      if (v1 && wr_en) begin
        acc[st1] <= wr_val;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cxu.req_insn, d_x[W+1:W]};
endmodule

// File: tb/tb_bnn_acc_l1_cxu.sv
// Table-driven and random scoreboard bench for bnn_acc_l1_cxu (W=32, 4 states).
module tb_bnn_acc_l1_cxu;
  import cxu_pkg::*;
  import bnn_acc_pkg::*;

  typedef struct {
    logic [2:0]  func;
    logic [3:0]  state;
    logic [3:0]  cx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [2:0]  status;
  } vec_t;

  typedef struct {
    logic [5:0]  id;
    logic [2:0]  status;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_acc_l1_cxu_if #(.DATA_W(32), .FUNC_ID_W(3)) bus ();

  bnn_acc_l1_cxu #(
    .CXU_N_CXUS    (1),
    .CXU_N_STATES  (4),
    .CXU_LAT       (2),
    .CXU_RESET_LAT (0),
    .CXU_FUNC_ID_W (3),
    .CXU_DATA_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cxu (bus)
  );

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   macc[4];
  vec_t tbl[24];

  localparam logic [2:0] S = CXU_STATUS_SUCCESS;
  localparam logic [2:0] E = CXU_STATUS_ERROR;

  function automatic vec_t mk(
    input logic [2:0] f, input logic [3:0] st,
    input logic [3:0] cx, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] d,
    input logic [2:0] s);
    vec_t v;
    v.func = f; v.state = st; v.cx = cx;
    v.a = a; v.b = b; v.data = d; v.status = s;
    return v;
  endfunction

  function automatic void model(
    input logic [2:0] f, input logic [3:0] st,
    input logic [3:0] cx, input logic [31:0] a,
    input logic [31:0] b, output logic [31:0] data,
    output logic [2:0] status);
    int     d;
    longint s;
    d      = 2 * $countones(~(a ^ b)) - 32;
    data   = '0;
    status = S;
    if (f > 3'd5 || st >= 4'd4 || cx != 4'd0) begin
      status = E;
      return;
    end
    case (f)
      3'd0: data = d;
      3'd1: begin
        s = longint'(macc[st]) + longint'(d);
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        macc[st] = int'(s);
        data = macc[st];
      end
      3'd2: data = macc[st];
      3'd3: begin data = macc[st]; macc[st] = a; end
      3'd4: data = (macc[st] >= $signed(a)) ? 32'd1 : 32'd0;
      default: begin data = macc[st]; macc[st] = 0; end
    endcase
  endfunction

  // Drives one cycle starting just after a negedge; ends at the next negedge.
  task automatic drive(
    input logic v, input logic [5:0] id, input logic [2:0] f,
    input logic [3:0] st, input logic [3:0] cx,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] ed, input logic [2:0] es);
    exp_t e;
    bus.req_valid = v;
    bus.req_id    = id;
    bus.req_func  = f;
    bus.req_state = st;
    bus.req_cxu   = cx;
    bus.req_data0 = a;
    bus.req_data1 = b;
    bus.req_insn  = $urandom;
    if (v && !rst) begin
      e.id = id; e.status = es; e.data = ed; e.due = cyc + 2;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 4; i++) macc[i] = 0;
  endtask

  task automatic model_drive(
    input logic [5:0] id, input logic [2:0] f,
    input logic [3:0] st, input logic [3:0] cx,
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] md;
    logic [2:0]  ms;
    model(f, st, cx, a, b, md, ms);
    drive(1, id, f, st, cx, a, b, md, ms);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got id=%0d data=%h at cyc %0d, required no response",
                   bus.resp_id, bus.resp_data, cyc);
        end else begin
          e = q.pop_front();
          if (bus.resp_id != e.id || bus.resp_status != e.status ||
              bus.resp_data != e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL resp: got id=%0d st=%0d data=%h cyc=%0d, required id=%0d st=%0d data=%h cyc=%0d",
                     bus.resp_id, bus.resp_status, bus.resp_data, cyc,
                     e.id, e.status, e.data, e.due);
          end
        end
      end else if (bus.resp_id != '0 || bus.resp_data != '0) begin
        n_fail++;
        $display("FAIL idle_zero: got id=%0d data=%h, required 0 and 0",
                 bus.resp_id, bus.resp_data);
      end
    end
  endtask

  initial begin
    logic [31:0] md;
    logic [2:0]  ms;
    logic [2:0]  f;
    logic [3:0]  st;
    logic [3:0]  cx;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0]  = mk(FN_DOT,  0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd32, S);
    tbl[1]  = mk(FN_DOT,  0, 0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, S);
    tbl[2]  = mk(FN_CLR,  1, 0, 0, 0, 32'd0, S);
    tbl[3]  = mk(FN_MAC,  1, 0, 0, 0, 32'd32, S);
    tbl[4]  = mk(FN_MAC,  1, 0, 0, 0, 32'd64, S);
    tbl[5]  = mk(FN_MAC,  1, 0, 0, 0, 32'd96, S);
    tbl[6]  = mk(FN_GET,  1, 0, 0, 0, 32'd96, S);
    tbl[7]  = mk(FN_GET,  0, 0, 0, 0, 32'd0, S);
    tbl[8]  = mk(FN_SET,  2, 0, 32'h7FFF_FFF0, 0, 32'd0, S);
    tbl[9]  = mk(FN_MAC,  2, 0, 0, 0, 32'h7FFF_FFFF, S);
    tbl[10] = mk(FN_SET,  2, 0, 32'h8000_0010, 0, 32'h7FFF_FFFF, S);
    tbl[11] = mk(FN_MAC,  2, 0, 0, 32'hFFFF_FFFF, 32'h8000_0000, S);
    tbl[12] = mk(3'd7,    0, 0, 0, 0, 32'd0, E);
    tbl[13] = mk(FN_GET,  5, 0, 0, 0, 32'd0, E);
    tbl[14] = mk(FN_GET,  1, 1, 0, 0, 32'd0, E);
    tbl[15] = mk(FN_SET,  3, 1, 32'd5, 0, 32'd0, E);
    tbl[16] = mk(FN_GET,  3, 0, 0, 0, 32'd0, S);
    tbl[17] = mk(FN_SIGN, 1, 0, 32'd96, 0, 32'd1, S);
    tbl[18] = mk(FN_SIGN, 1, 0, 32'd97, 0, 32'd0, S);
    tbl[19] = mk(FN_SIGN, 2, 0, 32'h8000_0001, 0, 32'd0, S);
    tbl[20] = mk(FN_CLR,  1, 0, 0, 0, 32'd96, S);
    tbl[21] = mk(FN_GET,  1, 0, 0, 0, 32'd0, S);
    tbl[22] = mk(FN_DOT,  0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, S);
    tbl[23] = mk(FN_GET,  2, 0, 0, 0, 32'h8000_0000, S);

    bus.req_valid = 0; bus.req_id = 0; bus.req_func = 0;
    bus.req_state = 0; bus.req_cxu = 0; bus.req_insn = 0;
    bus.req_data0 = 0; bus.req_data1 = 0;
    clear_model();
    fork
      monitor();
    join_none

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors back-to-back; the model tracks state alongside.
    for (int i = 0; i < 24; i++) begin
      model(tbl[i].func, tbl[i].state, tbl[i].cx,
            tbl[i].a, tbl[i].b, md, ms);
      drive(1, 6'(i + 8), tbl[i].func, tbl[i].state, tbl[i].cx,
            tbl[i].a, tbl[i].b, tbl[i].data, tbl[i].status);
    end
    idle(3);

    // Reset strikes with one MAC in flight and another being presented.
    drive(1, 6'd50, FN_MAC, 4'd1, 4'd0, 0, 0, 32'd32, S);
    rst = 1'b1;
    clear_model();
    drive(1, 6'd51, FN_MAC, 4'd1, 4'd0, 0, 0, 32'd64, S);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      model(FN_GET, 4'(s), 0, 0, 0, md, ms);
      drive(1, 6'(60 + s), FN_GET, 4'(s), 4'd0, 0, 0, 32'd0, S);
    end
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        f  = 3'($urandom_range(0, 7));
        st = 4'($urandom_range(0, 5));
        cx = ($urandom_range(0, 15) == 0) ? 4'd1 : 4'd0;
        case ($urandom_range(0, 3))
          0: a = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
          1: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = ~a;
          default: b = $urandom;
        endcase
        model_drive(6'($urandom), f, st, cx, a, b);
      end
    end
    idle(4);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0",
               q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
